mshr_drain_ctrl: RTL and testbench
==================================

// Module: mshr_drain_ctrl
// PURPOSE
// - Drains the MSHR toward physical memory. It handles one MSHR entry at a time, the one at the head pointer (cur_ptr).
// - Waiting entry: fetch the line from pmem, then merge it into the MSHR with a load_line pulse.
// - Dirty entry: write the merged line back to pmem.
// - Any other valid entry: retire it with an inc_cur_ptr pulse.
// - After a fetch, emits a one-cycle fill pulse so the cache array can install the completed line.
// PARAMETERS
// TAG_W     11   line tag width (addr[15:5])
// OFFSET_W  5    byte offset width within a line
// LINE_W    256  line width in bits
// PORTS
// clk            in   1        rising-edge clock
// rst_n          in   1        synchronous active-low reset
// head_valid     in   1        MSHR head entry is valid (cur_ptr != empty_ptr)
// waiting_in     in   1        head entry still needs its line fetched
// dirty_in       in   1        head entry holds CPU write data
// tag_in         in   TAG_W    head entry tag
// line_in        in   LINE_W   head entry data (post-merge after load_line)
// load_line      out  1        one-cycle pulse: merge line_data_out into the head entry
// line_data_out  out  LINE_W   registered pmem read data
// inc_cur_ptr    out  1        one-cycle pulse: retire the head entry
// wb_lock        out  1        head entry is frozen; upstream must stall load_word to it
// fill_valid     out  1        one-cycle pulse: install fill_tag/fill_line into the cache
// fill_tag       out  TAG_W    tag of the installed line
// fill_line      out  LINE_W   merged line to install
// pmem_read      out  1        memory read request, level, held until pmem_resp
// pmem_write     out  1        memory write request, level, held until pmem_resp
// pmem_address   out  16       {tag, OFFSET_W'b0}
// pmem_wdata     out  LINE_W   write data
// pmem_rdata     in   LINE_W   read data, valid when pmem_resp is high
// pmem_resp      in   1        single-cycle completion
// retire_count   out  16       saturating count of retired entries
// BEHAVIOUR
// Reset (rst_n=0 at posedge):
// - State goes to IDLE; all request and pulse outputs go to 0; wb_lock=0.
// - line_data_out, pmem_address, fill_tag and retire_count go to 0.
// - Reset mid-transaction drops the request. pmem must tolerate the abandoned request.
// FSM states: IDLE, FETCH, MERGE, FILL, WB, RETIRE.
// - IDLE: when head_valid=1, latch tag_in into tag_r, then branch:
//     waiting_in=1 -> FETCH; else dirty_in=1 -> WB; else -> RETIRE.
//     Nothing happens while head_valid=0.
// - FETCH:
//     pmem_read=1 and pmem_address={tag_r,5'b0}.
//     On pmem_resp: capture pmem_rdata into line_data_out and go to MERGE.
// - MERGE: load_line=1 for exactly one cycle, then go to FILL.
// - FILL:
//     fill_valid=1, fill_tag=tag_r, fill_line=line_in (which is now merged).
//     Next state is WB if dirty_in=1, else RETIRE.
// - WB:
//     pmem_write=1, pmem_address={tag_r,5'b0}, pmem_wdata=line_in.
//     On pmem_resp go to RETIRE.
// - RETIRE:
//     inc_cur_ptr=1 for one cycle; retire_count += 1, saturating at 16'hFFFF.
//     Next state is IDLE. The earliest new entry starts 1 cycle later.
// - wb_lock=1 in MERGE, FILL, WB and RETIRE.
//     CPU word writes to a waiting entry during FETCH are legal; the MSHR merge keeps those bytes.
// - Latency, clean entry:
//     FETCH(n+1 cycles, pmem_resp on cycle n) + MERGE + FILL + RETIRE.
// - pmem_read and pmem_write are never high together.
//     The request drops on the cycle after pmem_resp.
// - pmem_resp outside FETCH/WB is ignored.
// - head_valid dropping mid-operation is ignored; the FSM completes on the latched entry.
// - Full MSHR: no special case. The drain proceeds normally.
// - tag_in is sampled only in IDLE; later changes to it are ignored.
// STRUCTURE
// - lc3b_types: lc3b_mpnc_tag, lc3b_32bytes, lc3b_word, and a new enum type lc3b_drain_state_t.
// - Single module. No sub-module is warranted; the FSM and datapath registers stay inline.
// TESTING
// 1. Clean read miss:
//    head_valid=1, waiting=1, dirty=0, tag=11'h0A5.
//    -> pmem_read with address 16'h14A0.
//    -> resp with rdata=256'hDEAD.
//    -> load_line, then fill_valid with fill_tag=0A5, then inc_cur_ptr.
//    -> no pmem_write; retire_count=1.
// 2. Partial write miss:
//    waiting=1, dirty=1, tag=11'h001.
//    -> fetch 16'h0020, load_line, fill.
//    -> pmem_write with pmem_wdata=line_in, then retire. wb_lock=1 from MERGE through RETIRE.
// 3. Full dirty line:
//    waiting=0, dirty=1.
//    -> no pmem_read; pmem_write asserted 1 cycle after IDLE.
//    -> hold request over a 5-cycle pmem delay; retire on the cycle after resp.
// 4. Reset mid-WB:
//    rst_n=0 during WB.
//    -> next cycle pmem_write=0, state IDLE, retire_count=0, no inc_cur_ptr pulse.
// 5. Spurious pmem_resp in IDLE with head_valid=0 -> no outputs change.
// 6. Back-to-back entries, 3 clean entries with immediate resp:
//    -> three inc_cur_ptr pulses, each separated by the full FSM cycle.
//    -> retire_count=3; saturation checked by forcing the count to FFFF and retiring once more.

Source files
------------

// File: rtl/mshr_drain_ctrl_pkg.sv
// Shared types for the MSHR drain controller.
//   lc3b_mpnc_tag      : line tag (addr[15:5])
//   lc3b_32bytes       : one cache line
//   lc3b_word          : 16-bit machine word / address
//   lc3b_drain_state_t : drain FSM state encoding (also exported on state_dbg)
package mshr_drain_ctrl_pkg;

    localparam int MDC_TAG_W    = 11;
    localparam int MDC_OFFSET_W = 5;
    localparam int MDC_LINE_W   = 256;

    typedef logic [MDC_TAG_W-1:0]  lc3b_mpnc_tag;
    typedef logic [MDC_LINE_W-1:0] lc3b_32bytes;
    typedef logic [15:0]           lc3b_word;

    typedef enum logic [2:0] {
        DS_IDLE   = 3'd0,
        DS_FETCH  = 3'd1,
        DS_MERGE  = 3'd2,
        DS_FILL   = 3'd3,
        DS_WB     = 3'd4,
        DS_RETIRE = 3'd5
    } lc3b_drain_state_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic lc3b_word sat_inc(input lc3b_word c);
        return (c == 16'hFFFF) ? c : c + 16'd1;
    endfunction

endpackage

// File: rtl/mshr_drain_ctrl.sv
// mshr_drain_ctrl: drains the MSHR head entry (cur_ptr) toward physical memory.
// A waiting entry is fetched from pmem, merged back into the MSHR (load_line),
// then installed into the cache (fill_valid). A dirty entry is written back.
// Every entry is finally retired with an inc_cur_ptr pulse.
//
// Ports
//   clk, rst_n                      clock, synchronous active-low reset
//   head_valid/waiting_in/dirty_in  head entry status
//   tag_in, line_in                 head entry tag and (merged) data
//   load_line, line_data_out        merge pulse and registered pmem read data
//   inc_cur_ptr                     retire pulse
//   wb_lock                         head entry frozen (MERGE..RETIRE)
//   fill_valid/fill_tag/fill_line   cache install pulse and payload
//   pmem_read/pmem_write/pmem_address/pmem_wdata/pmem_rdata/pmem_resp
//                                   physical memory port
//   retire_count                    saturating count of retired entries
//   state_dbg                       current FSM state (debug visibility)
//
// pmem handshake: pmem_read / pmem_write are levels that rise when the FSM
// enters FETCH / WB and stay high, with a stable address and write data,
// until the cycle in which pmem_resp is sampled high. pmem_resp is a single
// cycle completion; read data is taken only in that cycle. The request is
// low on the following cycle. pmem_resp while no request is up is ignored.
module mshr_drain_ctrl
    import mshr_drain_ctrl_pkg::*;
#(
    parameter int TAG_W    = MDC_TAG_W,
    parameter int OFFSET_W = MDC_OFFSET_W,
    parameter int LINE_W   = MDC_LINE_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                head_valid,
    input  logic                waiting_in,
    input  logic                dirty_in,
    input  logic [TAG_W-1:0]    tag_in,
    input  logic [LINE_W-1:0]   line_in,
    output logic                load_line,
    output logic [LINE_W-1:0]   line_data_out,
    output logic                inc_cur_ptr,
    output logic                wb_lock,
    output logic                fill_valid,
    output logic [TAG_W-1:0]    fill_tag,
    output logic [LINE_W-1:0]   fill_line,
    output logic                pmem_read,
    output logic                pmem_write,
    output logic [15:0]         pmem_address,
    output logic [LINE_W-1:0]   pmem_wdata,
    input  logic [LINE_W-1:0]   pmem_rdata,
    input  logic                pmem_resp,
    output logic [15:0]         retire_count,
    output logic [2:0]          state_dbg
);

    lc3b_drain_state_t state, state_nx;
    logic [TAG_W-1:0]  tag_r;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= DS_IDLE;
            tag_r         <= '0;
            line_data_out <= '0;
            retire_count  <= '0;
        end else begin
            state <= state_nx;
            // The tag is frozen for the whole drain of this entry.
            if (state == DS_IDLE && head_valid) begin
                tag_r <= tag_in;
            end
            if (state == DS_FETCH && pmem_resp) begin
                line_data_out <= pmem_rdata;
            end
            if (state == DS_RETIRE) begin
                retire_count <= sat_inc(retire_count);
            end
        end
    end

    always_comb begin
        state_nx    = state;
        load_line   = 1'b0;
        inc_cur_ptr = 1'b0;
        wb_lock     = 1'b0;
        fill_valid  = 1'b0;
        pmem_read   = 1'b0;
        pmem_write  = 1'b0;
        case (state)
            DS_IDLE: begin
                if (head_valid) begin
                    if (waiting_in)    state_nx = DS_FETCH;
                    else if (dirty_in) state_nx = DS_WB;
                    else               state_nx = DS_RETIRE;
                end
            end
            DS_FETCH: begin
                // Not locked: CPU word writes into the waiting entry are still
                // allowed here and survive the merge.
                pmem_read = 1'b1;
                if (pmem_resp) state_nx = DS_MERGE;
            end
            DS_MERGE: begin
                load_line = 1'b1;
                wb_lock   = 1'b1;
                state_nx  = DS_FILL;
            end
            DS_FILL: begin
                fill_valid = 1'b1;
                wb_lock    = 1'b1;
                state_nx   = dirty_in ? DS_WB : DS_RETIRE;
            end
            DS_WB: begin
                pmem_write = 1'b1;
                wb_lock    = 1'b1;
                if (pmem_resp) state_nx = DS_RETIRE;
            end
            DS_RETIRE: begin
                inc_cur_ptr = 1'b1;
                wb_lock     = 1'b1;
                state_nx    = DS_IDLE;
            end
            default: state_nx = DS_IDLE;
        endcase
    end

    assign pmem_address = {tag_r, {OFFSET_W{1'b0}}};
    assign pmem_wdata   = line_in;
    assign fill_tag     = tag_r;
    assign fill_line    = line_in;
    assign state_dbg    = state;

endmodule

// File: tb/tb_mshr_drain_ctrl.sv
module tb_mshr_drain_ctrl;
    import mshr_drain_ctrl_pkg::*;

    localparam int EW = 52;
    localparam logic [3:0] EV_RD   = 4'd1;
    localparam logic [3:0] EV_LD   = 4'd2;
    localparam logic [3:0] EV_FILL = 4'd3;
    localparam logic [3:0] EV_WR   = 4'd4;
    localparam logic [3:0] EV_INC  = 4'd5;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    int   cyc_ctr = 0;
    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc_ctr <= cyc_ctr + 1;

    // ---------------- DUT signals ----------------
    logic         head_valid, waiting_in, dirty_in;
    logic [10:0]  tag_in;
    logic [255:0] line_in;
    logic         load_line, inc_cur_ptr, wb_lock, fill_valid;
    logic [255:0] line_data_out, fill_line, pmem_wdata, pmem_rdata;
    logic [10:0]  fill_tag;
    logic         pmem_read, pmem_write, pmem_resp;
    logic [15:0]  pmem_address, retire_count;
    logic [2:0]   state_dbg;

    mshr_drain_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .head_valid(head_valid), .waiting_in(waiting_in), .dirty_in(dirty_in),
        .tag_in(tag_in), .line_in(line_in),
        .load_line(load_line), .line_data_out(line_data_out),
        .inc_cur_ptr(inc_cur_ptr), .wb_lock(wb_lock),
        .fill_valid(fill_valid), .fill_tag(fill_tag), .fill_line(fill_line),
        .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
        .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
        .retire_count(retire_count), .state_dbg(state_dbg)
    );

    // ---------------- pmem model ----------------
    int           mem_delay = 0;
    logic [255:0] mem_rdata = '0;
    logic         mem_resp_m = 1'b0;
    logic [255:0] model_rdata = '0;
    logic         spur_resp = 1'b0;
    logic [255:0] spur_rdata = 256'h0BAD_0BAD;

    assign pmem_resp  = mem_resp_m | spur_resp;
    assign pmem_rdata = spur_resp ? spur_rdata : model_rdata;

    initial begin : pmem_model
        int cnt;
        cnt = 0;
        forever begin
            @(negedge clk);
            if (rst_n && (pmem_read || pmem_write) && !mem_resp_m) begin
                if (cnt >= mem_delay) begin
                    mem_resp_m  = 1'b1;
                    model_rdata = mem_rdata;
                    cnt         = 0;
                end else begin
                    cnt++;
                end
            end else begin
                mem_resp_m = 1'b0;
                cnt        = 0;
            end
        end
    end

    // ---------------- scoreboard ----------------
    logic [EW-1:0] exp_q[$];
    int total = 0;
    int bad   = 0;
    logic [15:0] exp_count = '0;

    task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic observe(input string nm, input logic [EW-1:0] got);
        logic [EW-1:0] e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL %s: got=%h expected=<none queued>", nm, got);
        end else begin
            e = exp_q.pop_front();
            if (e !== got) begin
                bad++;
                $display("FAIL %s: got=%h expected=%h", nm, got, e);
            end
        end
    endtask

    initial begin : monitor
        logic prev_rd, prev_wr;
        prev_rd = 1'b0;
        prev_wr = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_rd = 1'b0;
                prev_wr = 1'b0;
            end else begin
                if (pmem_read && !prev_rd)
                    observe("ev_read", {EV_RD, pmem_address, 32'h0});
                if (pmem_write && !prev_wr)
                    observe("ev_write", {EV_WR, pmem_address, pmem_wdata[31:0]});
                if (load_line)
                    observe("ev_load", {EV_LD, 16'h0, line_data_out[31:0]});
                if (fill_valid)
                    observe("ev_fill", {EV_FILL, {5'b0, fill_tag}, fill_line[31:0]});
                if (inc_cur_ptr)
                    observe("ev_retire", {EV_INC, retire_count, 32'h0});
                prev_rd = pmem_read;
                prev_wr = pmem_write;
            end
        end
    end

    // ---------------- driver tasks ----------------
    int m_rd, m_wr, m_lock, m_first_wr, m_last_wr, m_inc_cyc;
    int inc_at[$];

    // Presents one head entry, queues its expected events, plays the MSHR
    // side (merge on load_line), and returns in the retire cycle.
    task automatic run_entry(input logic w, input logic d, input logic [10:0] tag,
                             input logic [15:0] exp_addr, input logic [255:0] rdata,
                             input logic [255:0] cpu_data, input logic [255:0] cpu_mask,
                             input logic [31:0] exp_m32, input int delay, input bit drop_hv);
        logic [255:0] merged;
        int  cyc;
        bit  done;
        merged = (rdata & ~cpu_mask) | (cpu_data & cpu_mask);
        if (w) begin
            exp_q.push_back({EV_RD, exp_addr, 32'h0});
            exp_q.push_back({EV_LD, 16'h0, rdata[31:0]});
            exp_q.push_back({EV_FILL, {5'b0, tag}, exp_m32});
        end
        if (d) exp_q.push_back({EV_WR, exp_addr, exp_m32});
        exp_q.push_back({EV_INC, exp_count, 32'h0});
        exp_count = (exp_count == 16'hFFFF) ? exp_count : exp_count + 16'd1;

        mem_delay  = delay;
        mem_rdata  = rdata;
        line_in    = w ? (cpu_data & cpu_mask) : cpu_data;
        head_valid = 1'b1;
        waiting_in = w;
        dirty_in   = d;
        tag_in     = tag;
        m_rd = 0; m_wr = 0; m_lock = 0; m_first_wr = 0; m_last_wr = 0; m_inc_cyc = 0;
        cyc = 0;
        done = 1'b0;
        while (!done && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
            // Once the FSM is busy, disturb the inputs it must no longer look at.
            if (pmem_read || pmem_write || wb_lock) begin
                tag_in = ~tag;
                if (drop_hv) head_valid = 1'b0;
            end
            if (pmem_read) m_rd++;
            if (pmem_write) begin
                if (m_first_wr == 0) m_first_wr = cyc;
                m_last_wr = cyc;
                m_wr++;
            end
            if (wb_lock) m_lock++;
            if (load_line) begin
                line_in    = merged;
                waiting_in = 1'b0;
            end
            if (inc_cur_ptr) begin
                m_inc_cyc = cyc;
                inc_at.push_back(cyc_ctr);
                done = 1'b1;
            end
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL run_timeout: tag=%h no retire within 200 cycles", tag);
        end
    endtask

    task automatic idle_head();
        head_valid = 1'b0;
        waiting_in = 1'b0;
        dirty_in   = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin : main
        int waited;
        rst_n      = 1'b0;
        head_valid = 1'b1;
        waiting_in = 1'b1;
        dirty_in   = 1'b1;
        tag_in     = 11'h155;
        line_in    = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_pmem_read",    {255'b0, pmem_read},   256'd0);
        check("rst_pmem_write",   {255'b0, pmem_write},  256'd0);
        check("rst_load_line",    {255'b0, load_line},   256'd0);
        check("rst_inc_cur_ptr",  {255'b0, inc_cur_ptr}, 256'd0);
        check("rst_fill_valid",   {255'b0, fill_valid},  256'd0);
        check("rst_wb_lock",      {255'b0, wb_lock},     256'd0);
        check("rst_line_data",    line_data_out,         256'd0);
        check("rst_pmem_address", {240'b0, pmem_address}, 256'd0);
        check("rst_fill_tag",     {245'b0, fill_tag},    256'd0);
        check("rst_retire_count", {240'b0, retire_count}, 256'd0);
        check("rst_state",        {253'b0, state_dbg},   256'd0);
        head_valid = 1'b0;
        waiting_in = 1'b0;
        dirty_in   = 1'b0;
        rst_n      = 1'b1;
        @(posedge clk);
        #1;

        // 1. clean read miss
        run_entry(1'b1, 1'b0, 11'h0A5, 16'h14A0, 256'hDEAD, '0, '0, 32'h0000_DEAD, 0, 1'b0);
        check("t1_read_cycles",  256'(m_rd), 256'd1);
        check("t1_no_write",     256'(m_wr), 256'd0);
        check("t1_latency",      256'(m_inc_cyc), 256'd4);
        idle_head();
        check("t1_retire_count", {240'b0, retire_count}, 256'd1);

        // 2. partial write miss: CPU word 16'hBEEF must survive the merge
        run_entry(1'b1, 1'b1, 11'h001, 16'h0020, 256'h1111_2222_3333_4444,
                  256'hBEEF, 256'hFFFF, 32'h3333_BEEF, 0, 1'b0);
        check("t2_lock_cycles",  256'(m_lock), 256'd4);
        check("t2_read_cycles",  256'(m_rd), 256'd1);
        check("t2_write_cycles", 256'(m_wr), 256'd1);
        idle_head();
        check("t2_retire_count", {240'b0, retire_count}, 256'd2);

        // 3. full dirty line, 5-cycle pmem delay, head_valid dropped mid-way
        run_entry(1'b0, 1'b1, 11'h2C3, 16'h5860, '0, 256'hCAFE_F00D, '0,
                  32'hCAFE_F00D, 5, 1'b1);
        check("t3_no_read",      256'(m_rd), 256'd0);
        check("t3_first_write",  256'(m_first_wr), 256'd1);
        check("t3_write_held",   256'(m_wr), 256'd6);
        check("t3_retire_cycle", 256'(m_inc_cyc), 256'd7);
        idle_head();
        check("t3_retire_count", {240'b0, retire_count}, 256'd3);

        // 5. spurious pmem_resp while idle
        spur_resp = 1'b1;
        @(posedge clk);
        #1;
        spur_resp = 1'b0;
        @(posedge clk);
        #1;
        check("t5_pmem_read",    {255'b0, pmem_read},  256'd0);
        check("t5_pmem_write",   {255'b0, pmem_write}, 256'd0);
        check("t5_wb_lock",      {255'b0, wb_lock},    256'd0);
        check("t5_line_data",    line_data_out, 256'h1111_2222_3333_4444);
        check("t5_retire_count", {240'b0, retire_count}, 256'd3);
        check("t5_state",        {253'b0, state_dbg}, 256'd0);

        // 4. reset during WB
        exp_q.push_back({EV_WR, 16'h7FE0, 32'h1234_5678});
        mem_delay  = 20;
        line_in    = 256'h1234_5678;
        head_valid = 1'b1;
        waiting_in = 1'b0;
        dirty_in   = 1'b1;
        tag_in     = 11'h3FF;
        waited     = 0;
        do begin
            @(posedge clk);
            #1;
            waited++;
        end while (!pmem_write && waited < 10);
        check("t4_write_started", {255'b0, pmem_write}, 256'd1);
        repeat (2) @(posedge clk);
        #1;
        head_valid = 1'b0;
        dirty_in   = 1'b0;
        rst_n      = 1'b0;
        @(posedge clk);
        #1;
        check("t4_write_dropped", {255'b0, pmem_write},  256'd0);
        check("t4_state_idle",    {253'b0, state_dbg},   256'd0);
        check("t4_count_cleared", {240'b0, retire_count}, 256'd0);
        check("t4_no_retire",     {255'b0, inc_cur_ptr}, 256'd0);
        rst_n = 1'b1;
        exp_count = '0;
        @(posedge clk);
        #1;
        check("t4_no_retire_after", {255'b0, inc_cur_ptr}, 256'd0);
        check("t4_wb_lock_after",   {255'b0, wb_lock},     256'd0);

        // 6. three clean entries back to back
        inc_at.delete();
        run_entry(1'b1, 1'b0, 11'h010, 16'h0200, 256'h1000, '0, '0, 32'h0000_1000, 0, 1'b0);
        run_entry(1'b1, 1'b0, 11'h011, 16'h0220, 256'h2000, '0, '0, 32'h0000_2000, 0, 1'b0);
        run_entry(1'b1, 1'b0, 11'h012, 16'h0240, 256'h3000, '0, '0, 32'h0000_3000, 0, 1'b0);
        idle_head();
        check("t6_retire_count", {240'b0, retire_count}, 256'd3);
        check("t6_pulses", 256'(inc_at.size()), 256'd3);
        if (inc_at.size() == 3) begin
            check("t6_gap_1", 256'(inc_at[1] - inc_at[0]), 256'd5);
            check("t6_gap_2", 256'(inc_at[2] - inc_at[1]), 256'd5);
        end

        // saturation: start the counter at its ceiling and retire once more
        force dut.retire_count = 16'hFFFF;
        @(posedge clk);
        #1;
        release dut.retire_count;
        exp_count = 16'hFFFF;
        run_entry(1'b0, 1'b0, 11'h055, 16'h0AA0, '0, 256'h5A5A, '0, 32'h0000_5A5A, 0, 1'b0);
        idle_head();
        check("sat_retire_count", {240'b0, retire_count}, 256'hFFFF);

        repeat (2) @(posedge clk);
        #1;
        check("queue_drained", 256'(exp_q.size()), 256'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog expired");
    end

endmodule
